// File: rtl/fifo_prog_if.sv
// Producer/consumer bundle for fifo_prog. The master modport is the user side,
// the slave modport is the FIFO side.
interface fifo_prog_if #(
    parameter int NB_DATA = 8,
    parameter int NB_ADDR = 4
);
    logic               i_clr;
    logic               i_wr;
    logic [NB_DATA-1:0] i_wdata;
    logic               i_rd;
    logic [NB_DATA-1:0] o_rdata;
    logic               o_empty;
    logic               o_full;
    logic               o_almost_empty;
    logic               o_almost_full;
    logic [NB_ADDR:0]   o_count;
    logic               o_overflow;
    logic               o_underflow;

    modport master (
        output i_clr, i_wr, i_wdata, i_rd,
        input  o_rdata, o_empty, o_full, o_almost_empty, o_almost_full,
               o_count, o_overflow, o_underflow
    );

    modport slave (
        input  i_clr, i_wr, i_wdata, i_rd,
        output o_rdata, o_empty, o_full, o_almost_empty, o_almost_full,
               o_count, o_overflow, o_underflow
    );
endinterface

// File: rtl/fifo_prog.sv
// Single-clock FWFT FIFO with programmable almost flags, occupancy count and flush.
// Define FIFO_ERR_FLAGS_EN to build the sticky overflow/underflow flags.
module fifo_prog #(
    parameter int NB_DATA    = 8,
    parameter int NB_ADDR    = 4,
    parameter int AFULL_LVL  = 2**NB_ADDR - 2,
    parameter int AEMPTY_LVL = 2
) (
    input  logic              clk,
    input  logic              i_rst_n,
    fifo_prog_if.slave        bus
);
    localparam int               DEPTH    = 2**NB_ADDR;
    localparam logic [NB_ADDR:0] DEPTH_C  = {1'b1, {NB_ADDR{1'b0}}};
    localparam logic [NB_ADDR:0] AFULL_C  = AFULL_LVL[NB_ADDR:0];
    localparam logic [NB_ADDR:0] AEMPTY_C = AEMPTY_LVL[NB_ADDR:0];

    logic [NB_DATA-1:0] mem [DEPTH];
    logic [NB_ADDR-1:0] wptr;
    logic [NB_ADDR-1:0] rptr;
    logic [NB_ADDR:0]   count;
    logic               empty;
    logic               full;
    logic               wr_acc;
    logic               rd_acc;

    assign empty  = (count == '0);
    assign full   = (count == DEPTH_C);
    // When full, a simultaneous read frees the head slot, which is exactly wptr.
    assign wr_acc = bus.i_wr & (~full | bus.i_rd);
    assign rd_acc = bus.i_rd & ~empty;

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (bus.i_clr) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr_acc) wptr <= wptr + 1'b1;
            if (rd_acc) rptr <= rptr + 1'b1;
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (i_rst_n && !bus.i_clr && wr_acc) mem[wptr] <= bus.i_wdata;
    end

`ifdef FIFO_ERR_FLAGS_EN
    logic overflow;
    logic underflow;

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (bus.i_clr) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (bus.i_wr && !wr_acc) overflow  <= 1'b1;
            if (bus.i_rd && !rd_acc) underflow <= 1'b1;
        end
    end

    assign bus.o_overflow  = overflow;
    assign bus.o_underflow = underflow;
`else
    assign bus.o_overflow  = 1'b0;
    assign bus.o_underflow = 1'b0;
`endif

    assign bus.o_rdata        = empty ? '0 : mem[rptr];
    assign bus.o_empty        = empty;
    assign bus.o_full         = full;
    assign bus.o_almost_empty = (count <= AEMPTY_C);
    assign bus.o_almost_full  = (count >= AFULL_C);
    assign bus.o_count        = count;
endmodule

// File: tb/tb_fifo_prog.sv
// Directed bench for fifo_prog: fill/drain, boundary rd+wr, overflow/flush,
// pointer wrap against a queue model, and asynchronous reset mid-stream.
module tb_fifo_prog;
    logic clk;
    logic i_rst_n;
    int   vectors;
    int   miscompares;

`ifdef FIFO_ERR_FLAGS_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    fifo_prog_if #(.NB_DATA(8), .NB_ADDR(4)) bus ();

    fifo_prog #(.NB_DATA(8), .NB_ADDR(4), .AFULL_LVL(14), .AEMPTY_LVL(2)) dut (
        .clk     (clk),
        .i_rst_n (i_rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        bus.i_wr  = 1'b0;
        bus.i_rd  = 1'b0;
        bus.i_clr = 1'b0;
    endtask

    task automatic chk_flags(input string tag, input int n);
        chk({tag, "_count"}, 32'(bus.o_count), 32'(n));
        chk({tag, "_empty"}, 32'(bus.o_empty), 32'(n == 0));
        chk({tag, "_full"},  32'(bus.o_full),  32'(n == 16));
        chk({tag, "_aempty"}, 32'(bus.o_almost_empty), 32'(n <= 2));
        chk({tag, "_afull"},  32'(bus.o_almost_full),  32'(n >= 14));
    endtask

    logic [7:0] q[$];
    logic [7:0] nxt;
    int         occ;
    logic       do_wr;
    logic       do_rd;

    initial begin
        vectors     = 0;
        miscompares = 0;
        i_rst_n     = 1'b0;
        bus.i_wdata = '0;
        idle();
        repeat (2) @(negedge clk);

        chk_flags("rst", 0);
        chk("rst_rdata", 32'(bus.o_rdata), 32'h0);
        chk("rst_ovf", 32'(bus.o_overflow), 32'h0);
        chk("rst_unf", 32'(bus.o_underflow), 32'h0);

        i_rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus.i_wr    = 1'b1;
            bus.i_wdata = 8'(i);
            tick();
            chk_flags("fill", i + 1);
            chk("fill_rdata", 32'(bus.o_rdata), 32'h00);
        end

        // full boundary: head 0x00 pops while 0xA5 lands in the freed slot
        bus.i_wr    = 1'b1;
        bus.i_rd    = 1'b1;
        bus.i_wdata = 8'hA5;
        tick();
        chk_flags("fullrw", 16);
        chk("fullrw_rdata", 32'(bus.o_rdata), 32'h01);
        chk("fullrw_ovf", 32'(bus.o_overflow), 32'h0);

        bus.i_wr = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk("drain_rdata", 32'(bus.o_rdata), (i == 15) ? 32'hA5 : 32'(i + 1));
            bus.i_rd = 1'b1;
            tick();
            chk_flags("drain", 15 - i);
        end
        chk("drain_rdata_empty", 32'(bus.o_rdata), 32'h0);

        // empty boundary: write accepted, read rejected
        bus.i_wr    = 1'b1;
        bus.i_rd    = 1'b1;
        bus.i_wdata = 8'h3C;
        tick();
        idle();
        chk_flags("emptyrw", 1);
        chk("emptyrw_rdata", 32'(bus.o_rdata), 32'h3C);
        chk("emptyrw_unf", 32'(bus.o_underflow), 32'(ERR_EN));
        chk("emptyrw_ovf", 32'(bus.o_overflow), 32'h0);

        bus.i_clr = 1'b1;
        tick();
        idle();
        chk_flags("clr1", 0);
        chk("clr1_unf", 32'(bus.o_underflow), 32'h0);

        for (int i = 0; i < 16; i++) begin
            bus.i_wr    = 1'b1;
            bus.i_wdata = 8'(8'h10 + i);
            tick();
        end
        bus.i_wdata = 8'h77;
        tick();
        idle();
        chk_flags("ovf", 16);
        chk("ovf_flag", 32'(bus.o_overflow), 32'(ERR_EN));
        chk("ovf_rdata", 32'(bus.o_rdata), 32'h10);
        tick();
        chk("ovf_hold", 32'(bus.o_overflow), 32'(ERR_EN));

        // flush wins over a concurrent write and read
        bus.i_clr   = 1'b1;
        bus.i_wr    = 1'b1;
        bus.i_rd    = 1'b1;
        bus.i_wdata = 8'h99;
        tick();
        idle();
        chk_flags("clr2", 0);
        chk("clr2_ovf", 32'(bus.o_overflow), 32'h0);
        chk("clr2_unf", 32'(bus.o_underflow), 32'h0);
        chk("clr2_rdata", 32'(bus.o_rdata), 32'h0);

        // wrap-around with occupancy held in 1..3 against a queue model
        q.delete();
        nxt      = 8'h40;
        bus.i_wr = 1'b1;
        bus.i_wdata = nxt;
        q.push_back(nxt);
        nxt++;
        tick();
        for (int c = 0; c < 48; c++) begin
            occ   = q.size();
            do_wr = (occ < 3);
            do_rd = (occ > 1) && (c % 5 != 4);
            chk("wrap_rdata", 32'(bus.o_rdata), 32'(q[0]));
            bus.i_wr    = do_wr;
            bus.i_rd    = do_rd;
            bus.i_wdata = nxt;
            if (do_rd) void'(q.pop_front());
            if (do_wr) begin
                q.push_back(nxt);
                nxt++;
            end
            tick();
            chk("wrap_count", 32'(bus.o_count), 32'(q.size()));
        end
        idle();

        bus.i_clr = 1'b1;
        tick();
        idle();
        for (int i = 0; i < 9; i++) begin
            bus.i_wr    = 1'b1;
            bus.i_wdata = 8'(8'hC0 + i);
            tick();
        end
        chk("pre_arst_count", 32'(bus.o_count), 32'd9);
        bus.i_wdata = 8'hEE;
        #2 i_rst_n = 1'b0;
        #1;
        chk_flags("arst", 0);
        chk("arst_rdata", 32'(bus.o_rdata), 32'h0);
        chk("arst_ovf", 32'(bus.o_overflow), 32'h0);
        tick();
        idle();
        chk("arst_held_count", 32'(bus.o_count), 32'h0);
        i_rst_n     = 1'b1;
        bus.i_wr    = 1'b1;
        bus.i_wdata = 8'h5A;
        tick();
        idle();
        chk_flags("post_arst", 1);
        chk("post_arst_rdata", 32'(bus.o_rdata), 32'h5A);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
